// File: rtl/dmem_pipe_ctrl.sv
// Multi-cycle data-memory stage for the Y86-64 PIPE memory stage.
// Optional build macro DMEM_BYTE_ADDR_EN selects byte addressing with an alignment check.
module dmem_pipe_ctrl #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic [3:0]        M_icode,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [ADDR_W-1:0] M_valE,
    output logic [DATA_W-1:0] m_valM,
    output logic              m_done,
    output logic              m_stall,
    output logic              dmem_error
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $fatal(1, "dmem_pipe_ctrl: MEM_LAT must be in 1..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "dmem_pipe_ctrl: DEPTH must be a power of two");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, rd_q, bad_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   valm_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                dec_wr, dec_rd, dec_bad;
    logic [ADDR_W-1:0]   dec_addr;
    logic [IDX_W-1:0]    dec_idx;
    logic                accept;

    always_comb begin
        dec_wr   = (M_icode == 4'd4) || (M_icode == 4'd10) || (M_icode == 4'd8);
        dec_rd   = (M_icode == 4'd5) || (M_icode == 4'd9) || (M_icode == 4'd11);
        dec_addr = (dec_wr || M_icode == 4'd5) ? M_valE : M_valA;
`ifdef DMEM_BYTE_ADDR_EN
        dec_idx  = dec_addr[IDX_W+2:3];
        // Shift instead of multiplying DEPTH by 8 so the compare cannot overflow.
        dec_bad  = (dec_wr || dec_rd) &&
                   (({3'b000, dec_addr[ADDR_W-1:3]} >= ADDR_W'(DEPTH)) ||
                    (dec_addr[2:0] != 3'b000));
`else
        dec_idx  = dec_addr[IDX_W-1:0];
        dec_bad  = (dec_wr || dec_rd) && (dec_addr >= ADDR_W'(DEPTH));
`endif
    end

    assign accept = (state_q == IDLE) && m_req;

    // State register and latched request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= dec_wr;
                rd_q    <= dec_rd;
                bad_q   <= dec_bad;
                idx_q   <= dec_idx;
                wdata_q <= DATA_W'(M_valA);
            end
            if (state_q == DONE) begin
                if (rd_q && !bad_q) valm_q <= mem_q[idx_q];
                if (bad_q)          err_q  <= 1'b1;
            end
        end
    end

    // Array is not reset; a reset during DONE suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == DONE && wr_q && !bad_q)
            mem_q[idx_q] <= wdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (m_req) begin
                cnt_d   = CNT_INIT;
                state_d = (MEM_LAT == 1) ? DONE : BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_stall    = (state_q != IDLE);
        m_done     = (state_q == DONE);
        m_valM     = valm_q;
        dmem_error = err_q;
    end
endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Directed bench: three instances (MEM_LAT 1, 3, 4) share the request bus; m_req is steered to one.
module tb_dmem_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  icode = 4'd0;
    logic [63:0] valA = '0, valE = '0;
    logic [2:0]  reqv, stall, done, err;
    logic [63:0] valm [3];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;
    assign reqv = req ? (3'b001 << sel) : 3'b000;

    dmem_pipe_ctrl #(.MEM_LAT(1)) u_l1 (.clk(clk), .rst_n(rst_n), .m_req(reqv[0]), .M_icode(icode),
        .M_valA(valA), .M_valE(valE), .m_valM(valm[0]), .m_done(done[0]), .m_stall(stall[0]),
        .dmem_error(err[0]));
    dmem_pipe_ctrl #(.MEM_LAT(3)) u_l3 (.clk(clk), .rst_n(rst_n), .m_req(reqv[1]), .M_icode(icode),
        .M_valA(valA), .M_valE(valE), .m_valM(valm[1]), .m_done(done[1]), .m_stall(stall[1]),
        .dmem_error(err[1]));
    dmem_pipe_ctrl #(.MEM_LAT(4)) u_l4 (.clk(clk), .rst_n(rst_n), .m_req(reqv[2]), .M_icode(icode),
        .M_valA(valA), .M_valE(valE), .m_valM(valm[2]), .m_done(done[2]), .m_stall(stall[2]),
        .dmem_error(err[2]));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    // One access on instance k; checks stall length and done position, optionally
    // pulses a conflicting request during the first busy cycle.
    task automatic access(input int k, input logic [3:0] ic, input logic [63:0] ve,
                          input logic [63:0] va, input int lat, input bit pulse, input string tag);
        int n_stall, done_at, n_done;
        @(negedge clk);
        icode = ic; valE = ve; valA = va; sel = 2'(k); req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_stall = 0; done_at = 0; n_done = 0;
        for (int c = 1; c <= lat + 2; c++) begin
            if (stall[k]) n_stall++;
            if (done[k]) begin n_done++; if (done_at == 0) done_at = c; end
            if (pulse && c == 1) begin icode = 4'd4; valA = 64'hAA; req = 1'b1; end
            if (pulse && c == 2) req = 1'b0;
            if (c < lat + 2) @(negedge clk);
        end
        chk({tag, " stall"}, 64'(n_stall), 64'(lat));
        chk({tag, " done_at"}, 64'(done_at), 64'(lat));
        chk({tag, " n_done"}, 64'(n_done), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst stall", 64'(stall[k]), 64'd0);
            chk("rst done", 64'(done[k]), 64'd0);
            chk("rst valM", valm[k], 64'd0);
            chk("rst err", 64'(err[k]), 64'd0);
        end
        rst_n = 1'b1;
`ifdef DMEM_BYTE_ADDR_EN
        access(0, 4'd4, 64'h28, 64'h11, 1, 1'b0, "b_wr");
        access(0, 4'd5, 64'h28, 64'h0, 1, 1'b0, "b_rd");
        chk("b_rd valM", valm[0], 64'h11);
        chk("b_rd err", 64'(err[0]), 64'd0);
        access(0, 4'd4, 64'h2C, 64'h22, 1, 1'b0, "b_mis_wr");
        chk("b_mis err", 64'(err[0]), 64'd1);
        access(0, 4'd5, 64'h28, 64'h0, 1, 1'b0, "b_rd2");
        chk("b_rd2 valM", valm[0], 64'h11);
        access(0, 4'd5, 64'h2C, 64'h0, 1, 1'b0, "b_mis_rd");
        chk("b_mis_rd valM", valm[0], 64'h11);
        access(0, 4'd5, 64'h2000, 64'h0, 1, 1'b0, "b_oor");
        chk("b_oor valM", valm[0], 64'h11);
        chk("b_oor err", 64'(err[0]), 64'd1);
`else
        // MEM_LAT=1 basic write then read
        access(0, 4'd4, 64'd5, 64'hDEAD_BEEF, 1, 1'b0, "l1_wr");
        chk("l1_wr valM", valm[0], 64'd0);
        access(0, 4'd5, 64'd5, 64'd0, 1, 1'b0, "l1_rd");
        chk("l1_rd valM", valm[0], 64'hDEAD_BEEF);
        chk("l1_rd err", 64'(err[0]), 64'd0);
        // Out-of-range read: error set, valM held
        access(0, 4'd5, 64'd1024, 64'd0, 1, 1'b0, "oor_rd");
        chk("oor_rd valM", valm[0], 64'hDEAD_BEEF);
        chk("oor_rd err", 64'(err[0]), 64'd1);
        // Out-of-range writes aliasing index 5 must not land
        access(0, 4'd4, 64'd1029, 64'hBAD, 1, 1'b0, "oor_wr");
        access(0, 4'd10, 64'h1_0000_0005, 64'hBAD, 1, 1'b0, "oor_wr_hi");
        access(0, 4'd4, 64'd3, 64'h1234, 1, 1'b0, "l1_wr3");
        access(0, 4'd9, 64'd0, 64'd3, 1, 1'b0, "ret_rd");
        chk("ret_rd valM", valm[0], 64'h1234);
        chk("sticky err", 64'(err[0]), 64'd1);
        // No-op: timing only
        access(0, 4'd2, 64'd5, 64'hBAD, 1, 1'b0, "nop");
        chk("nop valM", valm[0], 64'h1234);
        access(0, 4'd5, 64'd5, 64'd0, 1, 1'b0, "l1_rd5");
        chk("l1_rd5 valM", valm[0], 64'hDEAD_BEEF);
        // MEM_LAT=3 pushq/popq at top index with an ignored mid-busy request
        access(1, 4'd10, 64'd1023, 64'h55, 3, 1'b1, "l3_push");
        chk("l3_push valM", valm[1], 64'd0);
        access(1, 4'd11, 64'd0, 64'd1023, 3, 1'b0, "l3_pop");
        chk("l3_pop valM", valm[1], 64'h55);
        access(1, 4'd2, 64'd1023, 64'h77, 3, 1'b0, "l3_nop");
        chk("l3_nop valM", valm[1], 64'h55);
        // MEM_LAT=4 call, read back, then reset during a second call
        access(2, 4'd8, 64'd7, 64'h77, 4, 1'b0, "l4_call");
        access(2, 4'd5, 64'd7, 64'd0, 4, 1'b0, "l4_rd");
        chk("l4_rd valM", valm[2], 64'h77);
        @(negedge clk);
        icode = 4'd8; valE = 64'd7; valA = 64'h99; sel = 2'd2; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("abort busy1", 64'(stall[2]), 64'd1);
        @(negedge clk);
        chk("abort busy2", 64'(stall[2]), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort stall", 64'(stall[2]), 64'd0);
        chk("abort done", 64'(done[2]), 64'd0);
        chk("abort valM", valm[2], 64'd0);
        chk("abort err l1", 64'(err[0]), 64'd0);
        rst_n = 1'b1;
        access(2, 4'd5, 64'd7, 64'd0, 4, 1'b0, "l4_rd2");
        chk("l4_rd2 valM", valm[2], 64'h77);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
